uop_sequencer: RTL and testbench
================================

// Module: uop_sequencer
// PURPOSE
//  Sequencing side of the microcoded control path: generates the uOP count and
//  holds the INSTR and flag state that the control ROM decodes. It consumes the
//  ROM's RESET_uOP, READ_FLAGS and IR_LOAD strobes, plus the ALU flags.
//  Provides run/halt/single-step control at instruction boundaries and a sticky
//  fault when a microprogram never terminates.
// PARAMETERS
//  MAX_UOP  5   last legal uOP index; reaching it without RESET_uOP -> fault
//  COUNT_W  16  width of retired-instruction counter
// PORTS
//  CLK          in   1        system clock, rising edge
//  RST_N        in   1        reset, asynchronous, active-low
//  RUN          in   1        level: 1 = free-run, 0 = halt at next instr boundary
//  STEP         in   1        1-cycle pulse: execute exactly one instruction from HALT
//  RESET_uOP    in   1        from control ROM: current uOP is the last of the instr
//  READ_FLAGS   in   1        from control ROM: capture ALU flags this cycle
//  IR_LOAD      in   1        from control ROM: capture BUS_IN into INSTR
//  BUS_IN       in   16       data bus
//  ALU_ZERO     in   1        ALU zero result
//  ALU_COUT     in   1        ALU carry out
//  uOP          out  3        microoperation index to control ROM
//  INSTR        out  16       instruction register to control ROM
//  ZERO_FLAG    out  1        latched zero flag
//  COUT_FLAG    out  1        latched carry flag
//  HALTED       out  1        1 while in INIT/HALT/FAULT
//  FAULT        out  1        sticky microprogram-overrun fault
//  INSTR_COUNT  out  COUNT_W  retired instructions, wraps modulo 2^COUNT_W
// BEHAVIOUR
//  Reset (async, RST_N=0): state=INIT, uOP=3'b111, INSTR=0, flags=0, HALTED=1,
//   FAULT=0, INSTR_COUNT=0. uOP=7 is the ROM idle state, held whenever not running.
//  States: INIT, HALT, RUN, STEP, FAULT. All transitions on rising CLK.
//  INIT: one cycle with uOP=7. Then RUN=1 -> RUN with uOP=0; else -> HALT.
//  HALT: uOP=7, HALTED=1.
//   RUN=1 -> RUN, uOP=0.
//   RUN=0 and STEP=1 -> STEP, uOP=0.
//  RUN/STEP: HALTED=0 from the first uOP=0 cycle.
//   RESET_uOP=1: INSTR_COUNT+=1 (wraps). Then:
//    - RUN state with RUN=1 -> uOP<=0.
//    - RUN state with RUN=0 -> HALT, uOP<=7.
//    - STEP state -> HALT, uOP<=7.
//   RESET_uOP=0 and uOP<MAX_UOP: uOP<=uOP+1.
//   RESET_uOP=0 and uOP==MAX_UOP: -> FAULT, uOP<=7, FAULT<=1. INSTR_COUNT is not
//    incremented.
//   RESET_uOP=1 with uOP==MAX_UOP: terminate normally; RESET_uOP wins, no fault.
//  RUN dropping mid-instruction never truncates it; the halt occurs at RESET_uOP.
//   STEP is ignored outside HALT, and while RUN=1.
//  FAULT: uOP=7, HALTED=1, FAULT=1. Exit only via RST_N.
//  IR_LOAD=1 in RUN/STEP: INSTR<=BUS_IN on that edge. Ignored in other states.
//  READ_FLAGS=1 in RUN/STEP: ZERO_FLAG<=ALU_ZERO, COUT_FLAG<=ALU_COUT. Flags
//   otherwise hold, including across halt and step.
//  Latency: the uOP, INSTR and flag updates are all visible the cycle after the
//   strobe edge.
//  Reset mid-instruction: all outputs immediately take their reset values.
// TESTING
//  Reset, then RUN=1: uOP sequence 7,0,1,2,3. RESET_uOP at uOP=3 -> next uOP=0,
//   INSTR_COUNT=1.
//  IR_LOAD with BUS_IN=16'h7380 at uOP=1 -> INSTR=16'h7380 next cycle. INSTR
//   holds through later uOPs.
//  READ_FLAGS with ALU_ZERO=1, ALU_COUT=0 -> ZERO_FLAG=1, COUT_FLAG=0. They hold
//   when ALU_ZERO toggles with READ_FLAGS=0.
//  RUN dropped at uOP=1, RESET_uOP at uOP=3 -> uOP=7, HALTED=1. STEP pulse ->
//   exactly one instr (0..3), back to HALT, INSTR_COUNT +1.
//  RESET_uOP never asserted, MAX_UOP=5 -> after uOP=5 FAULT=1, uOP=7 sticky.
//   RUN/STEP are ignored until RST_N.
//  INSTR_COUNT at 16'hFFFF plus one retire -> 16'h0000. RST_N pulled low at
//   uOP=2 -> uOP=7, INSTR=0 asynchronously.

Source files
------------

// File: rtl/uop_sequencer.sv
// Micro-op sequencer: uOP counter, instruction/flag latches and run/halt/step
// control at instruction boundaries, with a sticky overrun fault.
module uop_sequencer #(
    parameter int MAX_UOP = 5,
    parameter int COUNT_W = 16
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               RUN,
    input  logic               STEP,
    input  logic               RESET_uOP,
    input  logic               READ_FLAGS,
    input  logic               IR_LOAD,
    input  logic [15:0]        BUS_IN,
    input  logic               ALU_ZERO,
    input  logic               ALU_COUT,
    output logic [2:0]         uOP,
    output logic [15:0]        INSTR,
    output logic               ZERO_FLAG,
    output logic               COUT_FLAG,
    output logic               HALTED,
    output logic               FAULT,
    output logic [COUNT_W-1:0] INSTR_COUNT
);

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_HALT  = 3'd1,
        S_RUN   = 3'd2,
        S_STEP  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    localparam logic [2:0] LAST_UOP = 3'(MAX_UOP);
    localparam logic [2:0] IDLE_UOP = 3'b111;

    state_t             state_q, state_d;
    logic [2:0]         uop_q, uop_d;
    logic [15:0]        instr_q, instr_d;
    logic               zero_q, zero_d;
    logic               cout_q, cout_d;
    logic [COUNT_W-1:0] count_q, count_d;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_INIT;
            uop_q   <= IDLE_UOP;
            instr_q <= '0;
            zero_q  <= 1'b0;
            cout_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            uop_q   <= uop_d;
            instr_q <= instr_d;
            zero_q  <= zero_d;
            cout_q  <= cout_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        uop_d   = uop_q;
        instr_d = instr_q;
        zero_d  = zero_q;
        cout_d  = cout_q;
        count_d = count_q;
        case (state_q)
            S_INIT: begin
                if (RUN) begin
                    state_d = S_RUN;
                    uop_d   = 3'd0;
                end else begin
                    state_d = S_HALT;
                end
            end
            S_HALT: begin
                if (RUN) begin
                    state_d = S_RUN;
                    uop_d   = 3'd0;
                end else if (STEP) begin
                    state_d = S_STEP;
                    uop_d   = 3'd0;
                end
            end
            S_RUN, S_STEP: begin
                if (IR_LOAD) instr_d = BUS_IN;
                if (READ_FLAGS) begin
                    zero_d = ALU_ZERO;
                    cout_d = ALU_COUT;
                end
                // RESET_uOP takes priority over the overrun check at LAST_UOP
                if (RESET_uOP) begin
                    count_d = count_q + COUNT_W'(1);
                    if (state_q == S_RUN && RUN) begin
                        uop_d = 3'd0;
                    end else begin
                        state_d = S_HALT;
                        uop_d   = IDLE_UOP;
                    end
                end else if (uop_q < LAST_UOP) begin
                    uop_d = uop_q + 3'd1;
                end else begin
                    state_d = S_FAULT;
                    uop_d   = IDLE_UOP;
                end
            end
            S_FAULT: begin
                uop_d = IDLE_UOP;
            end
            default: begin
                state_d = S_FAULT;
                uop_d   = IDLE_UOP;
            end
        endcase
    end

    assign uOP         = uop_q;
    assign INSTR       = instr_q;
    assign ZERO_FLAG   = zero_q;
    assign COUT_FLAG   = cout_q;
    assign HALTED      = (state_q != S_RUN) && (state_q != S_STEP);
    assign FAULT       = (state_q == S_FAULT);
    assign INSTR_COUNT = count_q;

endmodule

// File: tb/tb_uop_sequencer.sv
// Bench for uop_sequencer: behavioural model checked every cycle plus
// directed literal expectations.
module tb_uop_sequencer;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b1;
    logic        RUN = 0, STEP = 0, RESET_uOP = 0, READ_FLAGS = 0, IR_LOAD = 0;
    logic [15:0] BUS_IN = '0;
    logic        ALU_ZERO = 0, ALU_COUT = 0;

    logic [2:0]  uop_o, w_uop;
    logic [15:0] instr_o, w_instr;
    logic        zf_o, cf_o, halt_o, fault_o;
    logic        w_zf, w_cf, w_halt, w_fault;
    logic [15:0] cnt_o;
    logic [3:0]  w_cnt;

    int total = 0;
    int bad = 0;

    always #5 CLK = ~CLK;

    uop_sequencer dut (
        .CLK(CLK), .RST_N(RST_N), .RUN(RUN), .STEP(STEP),
        .RESET_uOP(RESET_uOP), .READ_FLAGS(READ_FLAGS), .IR_LOAD(IR_LOAD),
        .BUS_IN(BUS_IN), .ALU_ZERO(ALU_ZERO), .ALU_COUT(ALU_COUT),
        .uOP(uop_o), .INSTR(instr_o), .ZERO_FLAG(zf_o), .COUT_FLAG(cf_o),
        .HALTED(halt_o), .FAULT(fault_o), .INSTR_COUNT(cnt_o)
    );

    // Narrow counter instance so wrap-around is reachable in few cycles
    uop_sequencer #(.MAX_UOP(5), .COUNT_W(4)) dut_w (
        .CLK(CLK), .RST_N(RST_N), .RUN(RUN), .STEP(STEP),
        .RESET_uOP(RESET_uOP), .READ_FLAGS(READ_FLAGS), .IR_LOAD(IR_LOAD),
        .BUS_IN(BUS_IN), .ALU_ZERO(ALU_ZERO), .ALU_COUT(ALU_COUT),
        .uOP(w_uop), .INSTR(w_instr), .ZERO_FLAG(w_zf), .COUT_FLAG(w_cf),
        .HALTED(w_halt), .FAULT(w_fault), .INSTR_COUNT(w_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: mode 0=init 1=halt 2=run 3=step 4=fault
    int m_mode = 0;
    int m_uop = 7;
    int m_instr = 0;
    int m_z = 0, m_c = 0;
    int m_cnt = 0;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_mode = 0; m_uop = 7; m_instr = 0;
            m_z = 0; m_c = 0; m_cnt = 0;
        end else if (m_mode == 0 || m_mode == 1) begin
            if (RUN) begin
                m_mode = 2; m_uop = 0;
            end else if (m_mode == 1 && STEP) begin
                m_mode = 3; m_uop = 0;
            end else begin
                m_mode = 1;
            end
        end else if (m_mode == 2 || m_mode == 3) begin
            if (IR_LOAD) m_instr = BUS_IN;
            if (READ_FLAGS) begin
                m_z = ALU_ZERO; m_c = ALU_COUT;
            end
            if (RESET_uOP) begin
                m_cnt = m_cnt + 1;
                if (m_mode == 2 && RUN) m_uop = 0;
                else begin m_mode = 1; m_uop = 7; end
            end else if (m_uop < 5) begin
                m_uop = m_uop + 1;
            end else begin
                m_mode = 4; m_uop = 7;
            end
        end
    end

    always @(negedge CLK) begin
        chk("m_uop", 32'(uop_o), 32'(m_uop));
        chk("m_instr", 32'(instr_o), 32'(m_instr));
        chk("m_zf", 32'(zf_o), 32'(m_z));
        chk("m_cf", 32'(cf_o), 32'(m_c));
        chk("m_halted", 32'(halt_o), 32'(m_mode < 2 || m_mode == 4));
        chk("m_fault", 32'(fault_o), 32'(m_mode == 4));
        chk("m_cnt", 32'(cnt_o), 32'(m_cnt % 65536));
        chk("m_wcnt", 32'(w_cnt), 32'(m_cnt % 16));
        chk("m_wuop", 32'(w_uop), 32'(m_uop));
    end

    task automatic cyc(input logic run, input logic step, input logic ru,
                       input logic rf, input logic irl,
                       input logic [15:0] bus, input logic z, input logic c);
        RUN = run; STEP = step; RESET_uOP = ru; READ_FLAGS = rf;
        IR_LOAD = irl; BUS_IN = bus; ALU_ZERO = z; ALU_COUT = c;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input logic run);
        cyc(run, 0, 0, 0, 0, 16'h0, 0, 0);
    endtask

    initial begin
        #1 RST_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_uop", 32'(uop_o), 32'd7);
        chk("rst_instr", 32'(instr_o), 32'd0);
        chk("rst_halted", 32'(halt_o), 32'd1);
        chk("rst_fault", 32'(fault_o), 32'd0);
        chk("rst_cnt", 32'(cnt_o), 32'd0);
        RST_N = 1'b1;
        chk("init_uop", 32'(uop_o), 32'd7);

        idle(1);
        chk("run_uop0", 32'(uop_o), 32'd0);
        chk("run_halted", 32'(halt_o), 32'd0);
        idle(1);
        chk("run_uop1", 32'(uop_o), 32'd1);
        cyc(1, 0, 0, 0, 1, 16'h7380, 0, 0);
        chk("ir_uop2", 32'(uop_o), 32'd2);
        chk("ir_load", 32'(instr_o), 32'h7380);
        cyc(1, 0, 0, 1, 0, 16'h0, 1, 0);
        chk("rf_uop3", 32'(uop_o), 32'd3);
        chk("rf_zero", 32'(zf_o), 32'd1);
        chk("rf_cout", 32'(cf_o), 32'd0);
        cyc(1, 0, 1, 0, 0, 16'h0, 0, 1);
        chk("retire_uop", 32'(uop_o), 32'd0);
        chk("retire_cnt", 32'(cnt_o), 32'd1);
        chk("zf_hold", 32'(zf_o), 32'd1);
        chk("ir_hold", 32'(instr_o), 32'h7380);

        cyc(1, 0, 0, 0, 0, 16'h0, 1, 0);
        idle(0);
        cyc(0, 1, 0, 0, 0, 16'h0, 0, 0);
        chk("drop_uop3", 32'(uop_o), 32'd3);
        cyc(0, 0, 1, 0, 0, 16'h0, 0, 0);
        chk("halt_uop", 32'(uop_o), 32'd7);
        chk("halt_halted", 32'(halt_o), 32'd1);
        chk("halt_cnt", 32'(cnt_o), 32'd2);
        cyc(0, 0, 0, 1, 1, 16'h1234, 0, 1);
        chk("halt_ir_ign", 32'(instr_o), 32'h7380);
        chk("halt_rf_ign", 32'(zf_o), 32'd1);

        cyc(0, 1, 0, 0, 0, 16'h0, 0, 0);
        chk("step_uop0", 32'(uop_o), 32'd0);
        chk("step_halted", 32'(halt_o), 32'd0);
        cyc(0, 1, 0, 0, 0, 16'h0, 0, 0);
        idle(0);
        cyc(0, 0, 0, 1, 0, 16'h0, 0, 1);
        chk("step_uop3", 32'(uop_o), 32'd3);
        chk("step_cf", 32'(cf_o), 32'd1);
        cyc(0, 0, 1, 0, 0, 16'h0, 0, 0);
        chk("step_done", 32'(uop_o), 32'd7);
        chk("step_cnt", 32'(cnt_o), 32'd3);
        idle(0);
        chk("step_stay", 32'(uop_o), 32'd7);

        repeat (6) idle(1);
        chk("max_uop", 32'(uop_o), 32'd5);
        cyc(1, 0, 1, 0, 0, 16'h0, 0, 0);
        chk("max_ok_uop", 32'(uop_o), 32'd0);
        chk("max_ok_fault", 32'(fault_o), 32'd0);
        chk("max_ok_cnt", 32'(cnt_o), 32'd4);

        repeat (6) idle(1);
        chk("ovf_uop", 32'(uop_o), 32'd7);
        chk("ovf_fault", 32'(fault_o), 32'd1);
        chk("ovf_cnt", 32'(cnt_o), 32'd4);
        cyc(0, 1, 0, 0, 0, 16'h0, 0, 0);
        idle(1);
        chk("fault_sticky", 32'(fault_o), 32'd1);
        chk("fault_uop", 32'(uop_o), 32'd7);

        RST_N = 1'b0;
        #1;
        chk("rst2_fault", 32'(fault_o), 32'd0);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        idle(1);
        cyc(1, 0, 0, 0, 1, 16'hABCD, 0, 0);
        chk("rst3_instr", 32'(instr_o), 32'hABCD);
        idle(1);
        chk("pre_async_uop", 32'(uop_o), 32'd2);
        RST_N = 1'b0;
        #1;
        chk("async_uop", 32'(uop_o), 32'd7);
        chk("async_instr", 32'(instr_o), 32'd0);
        chk("async_halted", 32'(halt_o), 32'd1);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;

        idle(1);
        repeat (18) cyc(1, 0, 1, 0, 0, 16'h0, 0, 0);
        chk("cnt18", 32'(cnt_o), 32'd18);
        chk("wrap_cnt", 32'(w_cnt), 32'd2);
        idle(0);
        idle(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
